// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// Widths are shared with the fetch stage and the memory model.
package imem_loader_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned HDR_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction memory write port of the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              byte_valid_i;
  logic [BYTE_W-1:0] byte_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_data_o;

  modport slave (
    input  byte_valid_i, byte_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output byte_valid_i, byte_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into a big-endian word; shared by header and data phases.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  localparam int unsigned CNT_W = $clog2(HDR_LEN);

  logic [CNT_W-1:0]         cnt_q;
  logic [WORD_W-BYTE_W-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (push) begin
      cnt_q <= cnt_q + 1'b1;
      sr_q  <= {sr_q[WORD_W-2*BYTE_W-1:0], byte_in};
    end
  end

  // The 4th byte completes the word combinationally so the owner captures it on that edge.
  assign full = push && (cnt_q == CNT_W'(HDR_LEN - 1));
  assign word = {sr_q, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses an address/count header, then writes big-endian words to
// the instruction memory while holding the processor in reset.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  imem_loader_if.slave       bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               cpu_hold_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       count_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WORD_W-1:0] wr_data_q;

  logic              ready;
  logic              we;
  logic              pk_clr;
  logic              pk_full;
  logic [WORD_W-1:0] pk_word;

  imem_loader_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (pk_clr),
    .push    (bus.byte_valid_i && ready),
    .byte_in (bus.byte_i),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    we         = 1'b0;
    pk_clr     = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    cpu_hold_o = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_HDR;
          pk_clr  = 1'b1;
        end
      end
      ST_HDR: begin
        ready  = 1'b1;
        busy_o = 1'b1;
        if (pk_full) state_d = (pk_word[15:0] == 16'd0) ? ST_DONE : ST_DATA;
      end
      ST_DATA: begin
        ready  = 1'b1;
        busy_o = 1'b1;
        if (pk_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        we      = 1'b1;
        busy_o  = 1'b1;
        state_d = (count_q == 16'd1) ? ST_DONE : ST_DATA;
      end
      ST_DONE: begin
        done_o     = 1'b0 | 1'b1;
        cpu_hold_o = 1'b0;
        if (start_i) begin
          state_d = ST_HDR;
          pk_clr  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write-port registers only change when entering WRITE, so they hold between words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        ST_HDR: if (pk_full) begin
          addr_q  <= pk_word[31:16];
          count_q <= pk_word[15:0];
        end
        ST_DATA: if (pk_full) begin
          wr_addr_q <= addr_q;
          wr_data_q <= pk_word;
        end
        ST_WRITE: begin
          addr_q  <= addr_q + 1'b1;
          count_q <= count_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready_o = ready;
  assign bus.mem_we_o     = we;
  assign bus.mem_addr_o   = wr_addr_q;
  assign bus.mem_data_o   = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard and memory model.
module tb_imem_loader;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk;
  logic rst;
  logic start_i;
  logic busy_o, done_o, cpu_hold_o;

  imem_loader_if bus ();

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .bus        (bus.slave),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cpu_hold_o (cpu_hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests  = 0;
  int          fails  = 0;
  int          writes = 0;
  wr_t         sb[$];
  logic [31:0] mem_model [0:65535];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.mem_we_o === 1'b1) begin
      wr_t e;
      writes++;
      if (sb.size() > 0) e = sb.pop_front();
      else               e = '{a: 'x, d: 'x};
      check("wr_addr", {16'h0, bus.mem_addr_o}, {16'h0, e.a});
      check("wr_data", bus.mem_data_o, e.d);
      mem_model[bus.mem_addr_o] = bus.mem_data_o;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
    bit ok;
    ok    = 1'b0;
    waits = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = b;
    for (int i = 0; i < 100; i++) begin
      if (bus.byte_ready_o === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      waits++;
    end
    if (!ok) check("byte_accept_timeout", {31'h0, bus.byte_ready_o}, 32'h1);
    #1 bus.byte_valid_i = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w, input int maxgap);
    int wt;
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[31:24], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, wt);
      v = v << 8;
    end
  endtask

  task automatic send_word(input logic [15:0] a, input logic [31:0] d, input int maxgap);
    sb.push_back('{a: a, d: d});
    send4(d, maxgap);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (done_o === 1'b1) break;
      @(negedge clk);
    end
    check(tag, {31'h0, done_o}, 32'h1);
  endtask

  initial begin
    int w0;
    int wt;
    rst              = 1'b1;
    start_i          = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_we",    {31'h0, bus.mem_we_o},     32'h0);
    check("rst_addr",  {16'h0, bus.mem_addr_o},   32'h0);
    check("rst_data",  bus.mem_data_o,            32'h0);
    check("rst_ready", {31'h0, bus.byte_ready_o}, 32'h0);
    check("rst_busy",  {31'h0, busy_o},           32'h0);
    check("rst_done",  {31'h0, done_o},           32'h0);
    check("rst_hold",  {31'h0, cpu_hold_o},       32'h1);
    rst = 1'b0;

    // IDLE ignores a presented byte
    @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = 8'h55;
    @(negedge clk);
    check("idle_ready", {31'h0, bus.byte_ready_o}, 32'h0);
    bus.byte_valid_i = 1'b0;

    // Zero-count header
    w0 = writes;
    pulse_start();
    @(negedge clk);
    check("start_ready", {31'h0, bus.byte_ready_o}, 32'h1);
    check("start_busy",  {31'h0, busy_o},           32'h1);
    check("start_hold",  {31'h0, cpu_hold_o},       32'h1);
    send4(32'h1234_0000, 0);
    @(negedge clk);
    check("zc_done",   {31'h0, done_o},         32'h1);
    check("zc_hold",   {31'h0, cpu_hold_o},     32'h0);
    check("zc_addr",   {16'h0, bus.mem_addr_o}, 32'h0);
    check("zc_writes", writes - w0,             32'h0);

    // Basic load from DONE, with a byte held across the WRITE cycle
    w0 = writes;
    pulse_start();
    @(negedge clk);
    check("restart_done", {31'h0, done_o},     32'h0);
    check("restart_hold", {31'h0, cpu_hold_o}, 32'h1);
    send4(32'h0010_0002, 0);
    send_word(16'h0010, 32'hDEAD_BEEF, 0);
    sb.push_back('{a: 16'h0011, d: 32'h0123_4567});
    send_byte(8'h01, 0, wt);
    check("held_byte_waits", wt, 32'd1);
    send_byte(8'h23, 0, wt);
    send_byte(8'h45, 0, wt);
    send_byte(8'h67, 0, wt);
    @(negedge clk);
    check("last_we",    {31'h0, bus.mem_we_o},     32'h1);
    check("last_ready", {31'h0, bus.byte_ready_o}, 32'h0);
    check("last_hold",  {31'h0, cpu_hold_o},       32'h1);
    check("last_done",  {31'h0, done_o},           32'h0);
    @(negedge clk);
    check("basic_done",   {31'h0, done_o},       32'h1);
    check("basic_hold",   {31'h0, cpu_hold_o},   32'h0);
    check("basic_we",     {31'h0, bus.mem_we_o}, 32'h0);
    check("basic_busy",   {31'h0, busy_o},       32'h0);
    check("basic_writes", writes - w0,           32'd2);
    check("basic_addr_hold", {16'h0, bus.mem_addr_o}, 32'h0011);
    check("basic_data_hold", bus.mem_data_o,          32'h0123_4567);

    // Address wrap-around
    w0 = writes;
    pulse_start();
    send4(32'hFFFF_0002, 0);
    send_word(16'hFFFF, 32'h1111_1111, 0);
    send_word(16'h0000, 32'h2222_2222, 0);
    wait_done("wrap_done");
    check("wrap_writes", writes - w0, 32'd2);

    // Random stalls with an ignored mid-load start
    w0 = writes;
    pulse_start();
    send4(32'h0010_0002, 3);
    send_word(16'h0010, 32'hDEAD_BEEF, 3);
    pulse_start();
    @(negedge clk);
    check("midstart_busy", {31'h0, busy_o}, 32'h1);
    send_word(16'h0011, 32'h0123_4567, 3);
    wait_done("stall_done");
    check("stall_writes", writes - w0, 32'd2);
    check("stall_sb",     sb.size(),   32'd0);

    // Reset after two bytes of a data word
    w0 = writes;
    pulse_start();
    send4(32'h0020_0001, 0);
    send_byte(8'hAA, 0, wt);
    send_byte(8'hBB, 0, wt);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_ready", {31'h0, bus.byte_ready_o}, 32'h0);
    check("mrst_we",    {31'h0, bus.mem_we_o},     32'h0);
    check("mrst_hold",  {31'h0, cpu_hold_o},       32'h1);
    check("mrst_busy",  {31'h0, busy_o},           32'h0);
    check("mrst_addr",  {16'h0, bus.mem_addr_o},   32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mrst_writes", writes - w0, 32'd0);

    pulse_start();
    send4(32'h0020_0001, 0);
    send_word(16'h0020, 32'hA5A5_5A5A, 1);
    wait_done("post_rst_done");

    // Reload from DONE, then read back the way the fetch stage would
    pulse_start();
    send4(32'h0009_0001, 0);
    send_word(16'h0009, 32'hCAFE_F00D, 0);
    wait_done("reload_done");
    check("reload_hold",  {31'h0, cpu_hold_o}, 32'h0);
    check("fetch_0009",   mem_model[16'h0009], 32'hCAFE_F00D);
    check("fetch_0010",   mem_model[16'h0010], 32'hDEAD_BEEF);
    check("fetch_ffff",   mem_model[16'hFFFF], 32'h1111_1111);
    check("fetch_0000",   mem_model[16'h0000], 32'h2222_2222);
    check("final_sb",     sb.size(),           32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
